// File: rtl/fr_track_pkg.sv
// Shared definitions for the resonant-frequency tracking blocks:
// sequencer state encoding, datapath widths and default frequency bounds.
package fr_track_pkg;

    localparam int ADC_W = 12;
    localparam int F_W   = 16;

    localparam logic [F_W-1:0] F_MIN_DEF = 16'd1000;
    localparam logic [F_W-1:0] F_MAX_DEF = 16'd60000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TICK,
        ST_CAPTURE,
        ST_INFER,
        ST_APPLY,
        ST_SWEEP
    } state_t;

endpackage

// File: rtl/freq_step_sat.sv
// Combinational frequency-word step: signed add, then either clamp to
// [F_MIN, F_MAX] or wrap back to F_MIN when the top bound is exceeded.
module freq_step_sat
    import fr_track_pkg::*;
#(
    parameter logic [F_W-1:0] F_MIN = F_MIN_DEF,
    parameter logic [F_W-1:0] F_MAX = F_MAX_DEF
) (
    input  logic                  [F_W-1:0] freq,
    input  logic signed           [F_W-1:0] step,
    input  logic                            wrap,
    output logic                  [F_W-1:0] result
);

    localparam logic signed [F_W+1:0] LO = $signed({2'b00, F_MIN});
    localparam logic signed [F_W+1:0] HI = $signed({2'b00, F_MAX});

    // Two guard bits keep the full unsigned word plus any signed step exact.
    logic signed [F_W+1:0] sum;

    function automatic logic [F_W-1:0] clamp_word(input logic signed [F_W+1:0] s);
        if (s > HI)
            return F_MAX;
        else if (s < LO)
            return F_MIN;
        else
            return s[F_W-1:0];
    endfunction

    function automatic logic [F_W-1:0] wrap_word(input logic signed [F_W+1:0] s);
        if (s > HI)
            return F_MIN;
        else
            return s[F_W-1:0];
    endfunction

    assign sum    = $signed({2'b00, freq}) + step;
    assign result = wrap ? wrap_word(sum) : clamp_word(sum);

endmodule

// File: rtl/fr_track_sequencer.sv
// Tracking-loop sequencer: samples current/phase each tick, handshakes with the
// fuzzy engine, applies the saturated correction, and sweeps while unlocked.
module fr_track_sequencer
    import fr_track_pkg::*;
#(
    parameter int              TICK_DIV   = 5000,
    parameter int              TIMEOUT    = 64,
    parameter logic [F_W-1:0]  F_MIN      = F_MIN_DEF,
    parameter logic [F_W-1:0]  F_MAX      = F_MAX_DEF,
    parameter logic [F_W-1:0]  SWEEP_STEP = 16'd8,
    parameter int              LOCK_TOL   = 1,
    parameter int              LOCK_CNT   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic        [ADC_W-1:0] adc_in_v,
    input  logic signed [F_W-1:0]   phase_diff,
    input  logic        [ADC_W-1:0] min_v,
    input  logic        [F_W-1:0]   f_init,
    output logic        [F_W-1:0]   E,
    output logic signed [F_W-1:0]   EC,
    output logic                    fz_start,
    input  logic                    fz_done,
    input  logic signed [F_W-1:0]   fz_delta,
    output logic        [F_W-1:0]   frequency_v,
    output logic                    locked,
    output logic                    timeout_err
);

    localparam int TCW = $clog2(TICK_DIV + 1);
    localparam int ICW = $clog2(TIMEOUT + 1);
    localparam int SCW = $clog2(LOCK_CNT + 1);

    localparam logic [TCW-1:0]      TICK_LAST = TCW'(TICK_DIV - 1);
    localparam logic [ICW-1:0]      INFER_LAST = ICW'(TIMEOUT - 1);
    localparam logic [SCW-1:0]      SETTLE_MAX = SCW'(LOCK_CNT);
    localparam logic signed [F_W:0] TOL = (F_W + 1)'(LOCK_TOL);

    state_t                 state;
    logic [TCW-1:0]         tick_cnt;
    logic [ICW-1:0]         infer_cnt;
    logic [SCW-1:0]         settle_cnt;
    logic signed [F_W-1:0]  delta_q;

    logic                   sweeping;
    logic signed [F_W-1:0]  step;
    logic [F_W-1:0]         next_freq;
    logic signed [F_W:0]    delta_x;
    logic signed [F_W:0]    delta_mag;
    logic                   settled;
    logic [SCW-1:0]         settle_next;

    assign sweeping = (state == ST_SWEEP);
    assign step     = sweeping ? $signed(SWEEP_STEP) : delta_q;

    freq_step_sat #(
        .F_MIN (F_MIN),
        .F_MAX (F_MAX)
    ) u_step (
        .freq   (frequency_v),
        .step   (step),
        .wrap   (sweeping),
        .result (next_freq)
    );

    // 17-bit magnitude so that -32768 has a representable absolute value.
    assign delta_x     = {delta_q[F_W-1], delta_q};
    assign delta_mag   = (delta_x < 0) ? -delta_x : delta_x;
    assign settled     = (delta_mag <= TOL);
    assign settle_next = (settle_cnt == SETTLE_MAX) ? settle_cnt : settle_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            tick_cnt    <= '0;
            infer_cnt   <= '0;
            settle_cnt  <= '0;
            delta_q     <= '0;
            frequency_v <= f_init;
            E           <= '0;
            EC          <= '0;
            fz_start    <= 1'b0;
            locked      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            fz_start <= 1'b0;
            if (state != ST_IDLE && !enable) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (enable) begin
                            state    <= ST_WAIT_TICK;
                            tick_cnt <= '0;
                        end
                    end
                    ST_WAIT_TICK: begin
                        if (tick_cnt == TICK_LAST)
                            state <= ST_CAPTURE;
                        else
                            tick_cnt <= tick_cnt + 1'b1;
                    end
                    ST_CAPTURE: begin
                        E  <= {{(F_W-ADC_W){1'b0}}, adc_in_v};
                        EC <= phase_diff;
                        if (adc_in_v < min_v) begin
                            locked     <= 1'b0;
                            settle_cnt <= '0;
                            state      <= ST_SWEEP;
                        end else begin
                            fz_start  <= 1'b1;
                            infer_cnt <= '0;
                            state     <= ST_INFER;
                        end
                    end
                    ST_INFER: begin
                        // A done arriving on the expiry cycle still counts.
                        if (fz_done) begin
                            delta_q <= fz_delta;
                            state   <= ST_APPLY;
                        end else if (infer_cnt == INFER_LAST) begin
                            timeout_err <= 1'b1;
                            tick_cnt    <= '0;
                            state       <= ST_WAIT_TICK;
                        end else begin
                            infer_cnt <= infer_cnt + 1'b1;
                        end
                    end
                    ST_APPLY: begin
                        frequency_v <= next_freq;
                        if (settled) begin
                            settle_cnt <= settle_next;
                            if (settle_next == SETTLE_MAX)
                                locked <= 1'b1;
                        end else begin
                            settle_cnt <= '0;
                            locked     <= 1'b0;
                        end
                        tick_cnt <= '0;
                        state    <= ST_WAIT_TICK;
                    end
                    ST_SWEEP: begin
                        frequency_v <= next_freq;
                        tick_cnt    <= '0;
                        state       <= ST_WAIT_TICK;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fr_track_sequencer.sv
// Scoreboard bench for fr_track_sequencer: expected frequency words are queued
// as each correction or sweep is provoked and popped when the DUT updates.
module tb_fr_track_sequencer;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic [11:0]        adc_in_v;
    logic signed [15:0] phase_diff;
    logic [11:0]        min_v;
    logic [15:0]        f_init;
    logic [15:0]        E;
    logic signed [15:0] EC;
    logic               fz_start;
    logic               fz_done;
    logic signed [15:0] fz_delta;
    logic [15:0]        frequency_v;
    logic               locked;
    logic               timeout_err;

    int tests = 0;
    int fails = 0;
    int model_freq;
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;

    fr_track_sequencer #(
        .TICK_DIV (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .adc_in_v    (adc_in_v),
        .phase_diff  (phase_diff),
        .min_v       (min_v),
        .f_init      (f_init),
        .E           (E),
        .EC          (EC),
        .fz_start    (fz_start),
        .fz_done     (fz_done),
        .fz_delta    (fz_delta),
        .frequency_v (frequency_v),
        .locked      (locked),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int clamp_model(input int s);
        if (s > 60000) return 60000;
        if (s < 1000) return 1000;
        return s;
    endfunction

    // Wait for a request, answer after 'lag' INFER cycles, stop one cycle past APPLY.
    task automatic do_infer(input int d, input int lag, output int lat);
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (fz_start) begin
                lat = i + 1;
                break;
            end
        end
        if (lat < 0) return;
        if (lag > 1) tick(lag - 1);
        fz_done  = 1'b1;
        fz_delta = 16'(d);
        model_freq = clamp_model(model_freq + d);
        exp_q.push_back(16'(model_freq));
        tick(1);
        fz_done = 1'b0;
        tick(1);
    endtask

    task automatic check_freq(input string name, input int lat);
        tests++;
        if (lat < 0 || exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: no fz_start seen (lat=%0d)", name, lat);
        end else begin
            exp_v = exp_q.pop_front();
            if (frequency_v !== exp_v) begin
                fails++;
                $display("FAIL %s: frequency_v=%0d expected %0d", name, frequency_v, exp_v);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; adc_in_v = '0; phase_diff = '0; min_v = 12'd100;
        f_init = 16'd30000; fz_done = 1'b0; fz_delta = '0;
        tick(3);
        rst = 1'b0;
        tick(1);
        model_freq = 30000;
        tests++; if (frequency_v !== 16'd30000) begin fails++; $display("FAIL reset_freq: %0d expected 30000", frequency_v); end
        tests++; if (E !== 16'd0) begin fails++; $display("FAIL reset_E: %0d expected 0", E); end
        tests++; if (EC !== 16'sd0) begin fails++; $display("FAIL reset_EC: %0d expected 0", EC); end
        tests++; if (fz_start !== 1'b0) begin fails++; $display("FAIL reset_fz_start: %b expected 0", fz_start); end
        tests++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked: %b expected 0", locked); end
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_timeout_err: %b expected 0", timeout_err); end
    endtask

    task automatic test_start_timing();
        int lat;
        adc_in_v = 12'd2000; phase_diff = -16'sd123;
        enable = 1'b1;
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (fz_start) begin lat = i + 1; break; end
        end
        tests++; if (lat != 6) begin fails++; $display("FAIL start_latency: %0d cycles expected 6", lat); end
        tests++; if (E !== 16'd2000) begin fails++; $display("FAIL capture_E: %0d expected 2000", E); end
        tests++; if (EC !== -16'sd123) begin fails++; $display("FAIL capture_EC: %0d expected -123", EC); end
        tick(1);
        tests++; if (fz_start !== 1'b0) begin fails++; $display("FAIL fz_start_width: %b expected 0", fz_start); end
        // Answer three cycles after the request.
        tick(1);
        fz_done = 1'b1; fz_delta = 16'sd500;
        model_freq = clamp_model(model_freq + 500);
        exp_q.push_back(16'(model_freq));
        tick(1);
        fz_done = 1'b0;
        tests++; if (frequency_v !== 16'd30000) begin fails++; $display("FAIL apply_early: %0d expected 30000", frequency_v); end
        tick(1);
        check_freq("apply_plus500", lat);
    endtask

    task automatic test_clamp();
        int lat;
        do_infer(32767, 2, lat);  check_freq("clamp_high", lat);
        do_infer(-32768, 1, lat); check_freq("step_down", lat);
        do_infer(-32768, 1, lat); check_freq("clamp_low", lat);
    endtask

    task automatic test_done_at_expiry();
        int lat;
        do_infer(7, 64, lat);
        check_freq("done_at_expiry_freq", lat);
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL done_at_expiry_err: %b expected 0", timeout_err); end
    endtask

    task automatic test_lock();
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_infer(0, 1, lat);
            check_freq("lock_hold_freq", lat);
            tests++;
            if (locked !== (i == 3)) begin
                fails++;
                $display("FAIL lock_after_%0d: locked=%b expected %b", i + 1, locked, (i == 3));
            end
        end
        do_infer(5, 1, lat);
        check_freq("unlock_plus5", lat);
        tests++; if (locked !== 1'b0) begin fails++; $display("FAIL unlock_locked: %b expected 0", locked); end
    endtask

    task automatic test_sweep();
        int lat;
        int bad;
        logic [15:0] old;
        do_infer(32767, 1, lat);
        check_freq("sweep_prep1", lat);
        do_infer(59996 - model_freq, 1, lat);
        check_freq("sweep_prep2", lat);
        adc_in_v = 12'd50;
        model_freq = 1000; exp_q.push_back(16'd1000);
        model_freq = 1008; exp_q.push_back(16'd1008);
        model_freq = 1016; exp_q.push_back(16'd1016);
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            old = frequency_v;
            for (int i = 0; i < 20; i++) begin
                tick(1);
                if (fz_start) bad++;
                if (frequency_v !== old) break;
            end
            check_freq("sweep_step", 1);
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL sweep_no_start: %0d requests expected 0", bad); end
        tests++; if (locked !== 1'b0) begin fails++; $display("FAIL sweep_locked: %b expected 0", locked); end
        tests++; if (E !== 16'd50) begin fails++; $display("FAIL sweep_E: %0d expected 50", E); end
        adc_in_v = 12'd2000;
    endtask

    task automatic test_timeout();
        int lat;
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (fz_start) begin lat = i + 1; break; end
        end
        tests++; if (lat < 0) begin fails++; $display("FAIL timeout_start: no fz_start"); end
        tick(63);
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL timeout_early: %b expected 0", timeout_err); end
        tick(1);
        tests++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL timeout_flag: %b expected 1", timeout_err); end
        tests++; if (frequency_v !== 16'(model_freq)) begin fails++; $display("FAIL timeout_freq: %0d expected %0d", frequency_v, model_freq); end
        do_infer(3, 1, lat);
        check_freq("after_timeout", lat);
        tests++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL timeout_sticky: %b expected 1", timeout_err); end
    endtask

    task automatic test_disable();
        int lat;
        int bad;
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (fz_start) begin lat = i + 1; break; end
        end
        tests++; if (lat < 0) begin fails++; $display("FAIL disable_start: no fz_start"); end
        tick(1);
        enable = 1'b0;
        tick(1);
        fz_done = 1'b1; fz_delta = 16'sd100;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (fz_start) bad++;
        end
        fz_done = 1'b0;
        tests++; if (frequency_v !== 16'(model_freq)) begin fails++; $display("FAIL disable_late_done: %0d expected %0d", frequency_v, model_freq); end
        tests++; if (bad != 0) begin fails++; $display("FAIL disable_fz_start: %0d pulses expected 0", bad); end
        enable = 1'b1;
        do_infer(2, 1, lat);
        tests++; if (lat != 6) begin fails++; $display("FAIL reenable_latency: %0d expected 6", lat); end
        check_freq("reenable_apply", lat);
    endtask

    task automatic test_reset_mid();
        int lat;
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (fz_start) begin lat = i + 1; break; end
        end
        tests++; if (lat < 0) begin fails++; $display("FAIL rstmid_start: no fz_start"); end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tests++; if (fz_start !== 1'b0) begin fails++; $display("FAIL rstmid_fz_start: %b expected 0", fz_start); end
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL rstmid_timeout_err: %b expected 0", timeout_err); end
        fz_done = 1'b1; fz_delta = 16'sd900;
        tick(2);
        fz_done = 1'b0;
        tests++; if (frequency_v !== 16'd30000) begin fails++; $display("FAIL rstmid_freq: %0d expected 30000", frequency_v); end
    endtask

    initial begin
        test_reset();
        test_start_timing();
        test_clamp();
        test_done_at_expiry();
        test_lock();
        test_sweep();
        test_timeout();
        test_disable();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
